store_align_buffer: RTL

Store-path counterpart to the load sign-extension logic. It takes store requests from the execute/mem stage (funct3 SB/SH/SW, byte address, register data) and computes the lane-shifted write data and 4-bit byte-enable mask. It rejects misaligned or illegal stores and queues legal ones in a small FIFO. The FIFO drains to data memory over a valid/ready handshake. A hazard output tells the load path when a pending store overlaps a load word.

---
 rtl/store_pkg.sv | 46 ++++
 rtl/store_fifo.sv | 76 +++++++
 rtl/store_align_buffer.sv | 111 +++++++++++
 3 files changed

// File: rtl/store_pkg.sv
// Shared types and helpers for the store alignment path.
package store_pkg;

  localparam int unsigned DATA_WIDTH = 32;
  localparam int unsigned BE_WIDTH   = 4;

  localparam logic [2:0] F3_SB = 3'b000;
  localparam logic [2:0] F3_SH = 3'b001;
  localparam logic [2:0] F3_SW = 3'b010;

  // One queued store: word address, lane-replicated data, byte enables.
  typedef struct packed {
    logic [DATA_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
    logic [BE_WIDTH-1:0]   be;
  } store_entry_t;

  // Natural alignment check; unknown funct3 encodings are rejected.
  function automatic logic store_is_legal(input logic [2:0] funct3,
                                          input logic [1:0] addr_lo);
    logic legal;
    legal = 1'b0;
    case (funct3)
      F3_SB:   legal = 1'b1;
      F3_SH:   legal = ~addr_lo[0];
      F3_SW:   legal = (addr_lo == 2'b00);
      default: legal = 1'b0;
    endcase
    return legal;
  endfunction

  // Byte-enable mask positioned at the addressed lane.
  function automatic logic [BE_WIDTH-1:0] store_be(input logic [2:0] funct3,
                                                   input logic [1:0] addr_lo);
    logic [BE_WIDTH-1:0] be;
    be = '0;
    case (funct3)
      F3_SB:   be = 4'b0001 << addr_lo;
      F3_SH:   be = 4'b0011 << addr_lo;
      F3_SW:   be = 4'b1111;
      default: be = '0;
    endcase
    return be;
  endfunction

endpackage

// File: rtl/store_fifo.sv
// Circular FIFO of store entries; exposes per-slot occupancy and word address.
module store_fifo
  import store_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                i_push,
  input  store_entry_t                        i_entry,
  input  logic                                i_pop,
  output store_entry_t                        o_head,
  output logic [$clog2(DEPTH):0]              o_count,
  output logic [DEPTH-1:0]                    o_entry_valid,
  output logic [DEPTH-1:0][DATA_WIDTH-3:0]    o_entry_word
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  store_entry_t  r_mem [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;

  logic          w_full;
  logic          w_empty;
  logic          w_push;
  logic          w_pop;
  logic [PW-1:0] w_off;

  assign w_full  = (r_count == CW'(DEPTH));
  assign w_empty = (r_count == '0);
  assign w_push  = i_push && !w_full;
  assign w_pop   = i_pop && !w_empty;

  // Entry storage; contents are don't-care until the slot is occupied.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_entry;
    end
  end

  // Pointers wrap naturally at DEPTH; count tracks occupancy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // A slot is occupied when its distance from the read pointer is below count.
  always_comb begin
    w_off         = '0;
    o_entry_valid = '0;
    o_entry_word  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_off            = PW'(i) - r_rd_ptr;
      o_entry_valid[i] = (CW'(w_off) < r_count);
      o_entry_word[i]  = r_mem[i].addr[DATA_WIDTH-1:2];
    end
  end

  assign o_head  = r_mem[r_rd_ptr];
  assign o_count = r_count;

endmodule

// File: rtl/store_align_buffer.sv
// Store path: legality check, lane replication, error capture, store queue
// and load-overlap hazard detection.
module store_align_buffer
  import store_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [2:0]              in_funct3,
  input  logic [DATA_WIDTH-1:0]   in_addr,
  input  logic [DATA_WIDTH-1:0]   in_data,
  output logic                    mem_valid,
  input  logic                    mem_ready,
  output logic [DATA_WIDTH-1:0]   mem_addr,
  output logic [DATA_WIDTH-1:0]   mem_wdata,
  output logic [3:0]              mem_be,
  output logic                    misalign_err,
  output logic [DATA_WIDTH-1:0]   err_addr,
  input  logic [DATA_WIDTH-1:0]   ld_addr,
  output logic                    ld_hazard,
  output logic [$clog2(DEPTH):0]  count
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic                               w_accept;
  logic                               w_legal;
  logic                               w_push;
  logic                               w_err;
  logic                               w_pop;
  logic                               w_hazard;
  logic                               w_unused_ld;
  store_entry_t                       w_entry;
  store_entry_t                       w_head;
  logic [CW-1:0]                      w_count;
  logic [DEPTH-1:0]                   w_entry_valid;
  logic [DEPTH-1:0][DATA_WIDTH-3:0]   w_entry_word;

  logic                               r_misalign_err;
  logic [DATA_WIDTH-1:0]              r_err_addr;

  // Full buffer refuses input regardless of a concurrent pop.
  assign in_ready    = (w_count != CW'(DEPTH));
  assign w_accept    = in_valid && in_ready;
  assign w_legal     = store_is_legal(in_funct3, in_addr[1:0]);
  assign w_push      = w_accept && w_legal;
  assign w_err       = w_accept && !w_legal;
  assign mem_valid   = (w_count != '0);
  assign w_pop       = mem_valid && mem_ready;
  assign w_unused_ld = ^ld_addr[1:0];

  // Replicate the narrow operand across all lanes so no shifter is needed.
  always_comb begin
    w_entry      = '0;
    w_entry.addr = {in_addr[DATA_WIDTH-1:2], 2'b00};
    w_entry.be   = store_be(in_funct3, in_addr[1:0]);
    case (in_funct3)
      F3_SB:   w_entry.wdata = {4{in_data[7:0]}};
      F3_SH:   w_entry.wdata = {2{in_data[15:0]}};
      default: w_entry.wdata = in_data;
    endcase
  end

  store_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk           (clk),
    .rst           (rst),
    .i_push        (w_push),
    .i_entry       (w_entry),
    .i_pop         (w_pop),
    .o_head        (w_head),
    .o_count       (w_count),
    .o_entry_valid (w_entry_valid),
    .o_entry_word  (w_entry_word)
  );

  // One-cycle error pulse; the faulting address is held until the next error.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_misalign_err <= 1'b0;
      r_err_addr     <= '0;
    end else begin
      r_misalign_err <= w_err;
      if (w_err) r_err_addr <= in_addr;
    end
  end

  // Any occupied entry in the same word as the load raises a hazard.
  always_comb begin
    w_hazard = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (w_entry_valid[i] && (w_entry_word[i] == ld_addr[DATA_WIDTH-1:2])) begin
        w_hazard = 1'b1;
      end
    end
  end

  assign mem_addr     = w_head.addr;
  assign mem_wdata    = w_head.wdata;
  assign mem_be       = w_head.be;
  assign misalign_err = r_misalign_err;
  assign err_addr     = r_err_addr;
  assign ld_hazard    = w_hazard;
  assign count        = w_count;

endmodule
